// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a handshake on both sides.
// Single-cycle operations complete on the accept edge. Shifts step one bit
// per cycle in a private shift register, and only the final step publishes
// the result and the {N,C,Z} flags.
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int AMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       flags,
   input  logic             flag_load,
   input  logic [2:0]       flag_in
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] OP_NOT  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_PASS = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_INC  = 4'b0111;
   localparam logic [3:0] OP_DEC  = 4'b1000;
   localparam logic [3:0] OP_SETC = 4'b1001;
   localparam logic [3:0] OP_CLRC = 4'b1010;
   localparam logic [3:0] OP_SHL  = 4'b1011;
   localparam logic [3:0] OP_SHR  = 4'b1100;

   localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

   state_t           state_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] shreg_r;
   logic [2:0]       flags_r;
   logic [AMT_W-1:0] count_r;
   logic             shl_r;

   logic [AMT_W-1:0] amt_s;
   logic [WIDTH-1:0] res_s;
   logic [WIDTH:0]   sum_s;
   logic             c_s;
   logic             upd_nz_s;
   logic             is_shift_s;
   logic [2:0]       op_flags_s;
   logic [WIDTH-1:0] sh_next_s;
   logic             sh_out_s;

   // Outputs come straight from registers.
   assign in_ready  = (state_r == IDLE);
   assign out_valid = (state_r == DONE);
   assign result    = result_r;
   assign flags     = flags_r;

   // Decode the requested operation into its result, carry and N/Z update enable.
   always_comb begin
      amt_s      = in1[AMT_W-1:0];
      res_s      = result_r;
      sum_s      = '0;
      c_s        = flags_r[1];
      upd_nz_s   = 1'b0;
      is_shift_s = 1'b0;
      case (alu_op)
         OP_NOT:  begin res_s = ~in2; upd_nz_s = 1'b1; end
         OP_ADD:  begin
            sum_s    = {1'b0, in1} + {1'b0, in2};
            res_s    = sum_s[WIDTH-1:0];
            c_s      = sum_s[WIDTH];
            upd_nz_s = 1'b1;
         end
         OP_PASS: begin res_s = in1; upd_nz_s = 1'b1; end
         OP_SUB:  begin res_s = in1 - in2; c_s = (in1 < in2); upd_nz_s = 1'b1; end
         OP_AND:  begin res_s = in1 & in2; upd_nz_s = 1'b1; end
         OP_OR:   begin res_s = in1 | in2; upd_nz_s = 1'b1; end
         OP_INC:  begin
            sum_s    = {1'b0, in2} + {{WIDTH{1'b0}}, 1'b1};
            res_s    = sum_s[WIDTH-1:0];
            c_s      = sum_s[WIDTH];
            upd_nz_s = 1'b1;
         end
         OP_DEC:  begin
            res_s    = in2 - {{(WIDTH-1){1'b0}}, 1'b1};
            c_s      = (in2 == {WIDTH{1'b0}});
            upd_nz_s = 1'b1;
         end
         OP_SETC: c_s = 1'b1;
         OP_CLRC: c_s = 1'b0;
         OP_SHL, OP_SHR: begin
            // A zero amount completes at once and keeps the carry.
            if (amt_s == {AMT_W{1'b0}}) begin
               res_s    = in2;
               upd_nz_s = 1'b1;
            end else begin
               is_shift_s = 1'b1;
            end
         end
         default: res_s = result_r;
      endcase
      op_flags_s = {upd_nz_s ? res_s[WIDTH-1] : flags_r[2],
                    c_s,
                    upd_nz_s ? (res_s == {WIDTH{1'b0}}) : flags_r[0]};
   end

   // Compute one shift step and the bit it pushes out.
   always_comb begin
      if (shl_r) begin
         sh_next_s = {shreg_r[WIDTH-2:0], 1'b0};
         sh_out_s  = shreg_r[WIDTH-1];
      end else begin
         sh_next_s = {1'b0, shreg_r[WIDTH-1:1]};
         sh_out_s  = shreg_r[0];
      end
   end

   // Control FSM and datapath registers; a flag restore overrides any flag update on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         result_r <= {WIDTH{1'b0}};
         shreg_r  <= {WIDTH{1'b0}};
         flags_r  <= 3'b000;
         count_r  <= {AMT_W{1'b0}};
         shl_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift_s) begin
                     shreg_r <= in2;
                     count_r <= (amt_s >= AMT_MAX) ? AMT_MAX : amt_s;
                     shl_r   <= (alu_op == OP_SHL);
                     state_r <= SHIFT;
                  end else begin
                     result_r <= res_s;
                     flags_r  <= op_flags_s;
                     state_r  <= DONE;
                  end
               end
            end
            SHIFT: begin
               shreg_r <= sh_next_s;
               count_r <= count_r - AMT_W'(1);
               if (count_r == AMT_W'(1)) begin
                  result_r <= sh_next_s;
                  flags_r  <= {sh_next_s[WIDTH-1], sh_out_s, (sh_next_s == {WIDTH{1'b0}})};
                  state_r  <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
         if (flag_load) begin
            flags_r <= flag_in;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table of operations with hand-computed
// results, flags and shift-cycle counts, plus sequences for DONE hold,
// flag restore and reset in the middle of a shift.
module tb_alu_seq;
   localparam int WIDTH = 16;
   localparam int AMT_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [3:0]       alu_op = 4'h0;
   logic [WIDTH-1:0] in1 = '0;
   logic [WIDTH-1:0] in2 = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] result;
   logic [2:0]       flags;
   logic             flag_load = 1'b0;
   logic [2:0]       flag_in = 3'b000;

   int n_cmp = 0;
   int n_bad = 0;

   alu_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .in1(in1), .in2(in2), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flags(flags),
      .flag_load(flag_load), .flag_in(flag_in)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic [2:0]  fl;
      int          cyc;
   } vec_t;

   vec_t vt[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for DONE; count cycles spent shifting.
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int shc, output logic ok);
      int waited;
      @(negedge clk);
      alu_op = op; in1 = a; in2 = b; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      shc = 0;
      waited = 0;
      while (!out_valid && waited < 100) begin
         if (!in_ready) shc++;
         @(negedge clk);
         waited++;
      end
      ok = out_valid;
   endtask

   task automatic release_done();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int   shc;
      logic ok;

      //             op     in1       in2       result    {N,C,Z} shift cycles
      vt[0]  = '{4'h2, 16'hFFFF, 16'h0001, 16'h0000, 3'b011, 0};  // ADD wrap
      vt[1]  = '{4'h4, 16'h0003, 16'h0005, 16'hFFFE, 3'b110, 0};  // SUB borrow
      vt[2]  = '{4'h5, 16'h00F0, 16'h0F00, 16'h0000, 3'b011, 0};  // AND keeps C
      vt[3]  = '{4'h1, 16'h0000, 16'h00FF, 16'hFF00, 3'b110, 0};  // NOT keeps C
      vt[4]  = '{4'hA, 16'h1111, 16'h2222, 16'hFF00, 3'b100, 0};  // CLRC
      vt[5]  = '{4'h3, 16'h1234, 16'hFFFF, 16'h1234, 3'b000, 0};  // PASS
      vt[6]  = '{4'h9, 16'h0000, 16'h0000, 16'h1234, 3'b010, 0};  // SETC
      vt[7]  = '{4'h6, 16'h8000, 16'h0001, 16'h8001, 3'b110, 0};  // OR
      vt[8]  = '{4'h7, 16'h0000, 16'hFFFF, 16'h0000, 3'b011, 0};  // INC carry
      vt[9]  = '{4'h8, 16'h0000, 16'h0000, 16'hFFFF, 3'b110, 0};  // DEC of 0
      vt[10] = '{4'h8, 16'h0000, 16'h0005, 16'h0004, 3'b000, 0};  // DEC
      vt[11] = '{4'h0, 16'hAAAA, 16'h5555, 16'h0004, 3'b000, 0};  // NOP
      vt[12] = '{4'hE, 16'hAAAA, 16'h5555, 16'h0004, 3'b000, 0};  // undefined code
      vt[13] = '{4'h9, 16'h0000, 16'h0000, 16'h0004, 3'b010, 0};  // SETC
      vt[14] = '{4'hB, 16'h0003, 16'h9001, 16'h8008, 3'b100, 3};  // SHL 3
      vt[15] = '{4'hC, 16'h0014, 16'h8001, 16'h0000, 3'b011, 16}; // SHR 20 -> 16 steps
      vt[16] = '{4'hB, 16'h0000, 16'h1234, 16'h1234, 3'b010, 0};  // SHL 0 keeps C
      vt[17] = '{4'hC, 16'h0004, 16'h00F8, 16'h000F, 3'b010, 4};  // SHR 4
      vt[18] = '{4'h4, 16'h0005, 16'h0003, 16'h0002, 3'b000, 0};  // SUB no borrow
      vt[19] = '{4'h2, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 0};  // ADD sign flip
      vt[20] = '{4'hB, 16'h0021, 16'h4000, 16'h8000, 3'b100, 1};  // amt masked to 1

      // Reset state while rst_n is held low.
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 21; i++) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, shc, ok);
         check($sformatf("v%0d_done", i), 32'(ok), 32'd1);
         check($sformatf("v%0d_result", i), 32'(result), 32'(vt[i].res));
         check($sformatf("v%0d_flags", i), 32'(flags), 32'(vt[i].fl));
         check($sformatf("v%0d_shift_cycles", i), 32'(shc), 32'(vt[i].cyc));
         release_done();
      end

      // DONE holds for 5 cycles without out_ready; an in_valid pulse is ignored.
      run_op(4'h2, 16'h0001, 16'h0002, shc, ok);
      check("hold_done", 32'(ok), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_result", 32'(result), 32'h0003);
         check("hold_flags", 32'(flags), 32'd0);
         alu_op = 4'h1; in2 = 16'h0000; in_valid = (i == 2);
         @(negedge clk);
      end
      in_valid = 1'b0;
      release_done();
      check("post_hold_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("post_hold_out_valid", 32'(out_valid), 32'd0);
      check("post_hold_result", 32'(result), 32'h0003);

      // Flag restore on the same edge an INC completes.
      alu_op = 4'h7; in2 = 16'h0010; in_valid = 1'b1; flag_load = 1'b1; flag_in = 3'b101;
      @(negedge clk);
      in_valid = 1'b0; flag_load = 1'b0;
      check("fl_inc_valid", 32'(out_valid), 32'd1);
      check("fl_inc_result", 32'(result), 32'h0011);
      check("fl_inc_flags", 32'(flags), 32'b101);
      release_done();
      flag_in = 3'b010; flag_load = 1'b1;
      @(negedge clk);
      flag_load = 1'b0;
      check("fl_idle_flags", 32'(flags), 32'b010);
      check("fl_idle_result", 32'(result), 32'h0011);

      // Reset in the middle of SHL by 10.
      alu_op = 4'hB; in1 = 16'h000A; in2 = 16'h0001; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_shift_busy", 32'({in_ready, out_valid}), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_result", 32'(result), 32'd0);
      check("arst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'h2, 16'h0002, 16'h0003, shc, ok);
      check("after_rst_done", 32'(ok), 32'd1);
      check("after_rst_latency", 32'(shc), 32'd0);
      check("after_rst_result", 32'(result), 32'h0005);
      check("after_rst_flags", 32'(flags), 32'd0);
      release_done();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits (minimum 4).
REQ-002 The block SHALL have parameter AMT_W, default 5, meaning the number of low bits of in1 used as the shift amount; its value SHALL be at least log2(WIDTH)+1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 alu_op  input  4  operation code, encoded as in REQ-014.
REQ-008 in1  input  WIDTH  operand 1; its low AMT_W bits are the shift amount.
REQ-009 in2  input  WIDTH  operand 2, signed.
REQ-010 out_valid  output  1  result and flags are valid.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 The block SHALL provide these flag-related ports: flags  output  3  registered {N,C,Z}; flag_load  input  1  overwrite the flags (interrupt restore); flag_in  input  3  {N,C,Z} value for flag_load.

Function
REQ-014 Opcodes SHALL be: 0000 NOP, 0001 NOT in2, 0010 ADD in1+in2, 0011 PASS in1, 0100 SUB in1-in2, 0101 AND, 0110 OR, 0111 INC in2+1, 1000 DEC in2-1, 1001 SETC, 1010 CLRC, 1011 SHL in2 by amt, 1100 SHR (logical) in2 by amt; codes 1101-1111 SHALL behave as NOP.
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE, and in_ready SHALL equal (state==IDLE).
REQ-016 IDLE SHALL accept an operation on an edge with in_valid=1; a non-shift operation, or a shift with amt=0, SHALL go to DONE on that edge (latency 1).
REQ-017 An accepted shift with amt>0 SHALL load in2 and count=min(amt,WIDTH), then go to SHIFT.
REQ-018 Each SHIFT edge SHALL shift by one bit and decrement count, and the edge that takes count to 0 SHALL enter DONE, so latency is min(amt,WIDTH) cycles.
REQ-019 DONE SHALL hold out_valid=1 with result and flags stable until an edge with out_ready=1, then return to IDLE; in_valid SHALL be ignored outside IDLE.
REQ-020 Arithmetic SHALL be modulo 2^WIDTH.
REQ-021 For ADD and INC, C SHALL be the carry out of bit WIDTH-1.
REQ-022 For SUB, C SHALL be the borrow (in1<in2 unsigned); for DEC, C SHALL be 1 iff in2==0.
REQ-023 For shifts, C SHALL be the last bit shifted out; a shift with amt=0 SHALL return in2 with C unchanged; a shift with amt>=WIDTH SHALL return 0.
REQ-024 N SHALL equal result[WIDTH-1] and Z SHALL equal (result==0), both updated by every operation except NOP, SETC and CLRC.
REQ-025 NOT, PASS, AND and OR SHALL leave C unchanged.
REQ-026 SETC SHALL set C to 1 and CLRC SHALL clear C to 0, leaving N, Z and result unchanged.
REQ-027 NOP SHALL leave result and all flags unchanged but still complete through DONE.
REQ-028 Flags and result SHALL update on the edge that enters DONE.
REQ-029 flag_load=1 SHALL write flag_in to flags on that edge in any state, with priority over an operation flag update on the same edge; result SHALL be unaffected.

Reset
REQ-030 While rst_n=0, the block SHALL immediately force state=IDLE, in_ready=1, out_valid=0, result=0, flags=3'b000 and count=0, including mid-SHIFT or mid-DONE; the aborted operation SHALL be discarded.
REQ-031 The first accept SHALL occur on the first edge with rst_n=1.

Verification
REQ-032 ADD in1=0xFFFF, in2=0x0001 -> out_valid 1 cycle after accept, result 0x0000, flags N=0 C=1 Z=1.
REQ-033 SUB in1=0x0003, in2=0x0005 -> result 0xFFFE, N=1 C=1 Z=0; a following AND 0x00F0 & 0x0F00 -> result 0x0000, N=0 C=1 (kept) Z=1.
REQ-034 SHL in1=3, in2=0x9001 -> in_ready=0 for 3 cycles, result 0x8008, N=1 C=0 Z=0; SHR in1=20, in2=0x8001 -> result 0x0000 after 16 cycles, Z=1.
REQ-035 out_ready=0 held 5 cycles in DONE -> out_valid, result and flags stable and in_ready=0; an in_valid pulse in that window is ignored.
REQ-036 Reset mid-SHIFT (SHL amt=10, rst_n low on cycle 4) -> out_valid=0, result=0, flags=000 without a clock edge; a new ADD completes normally after release.
REQ-037 flag_load=1 with flag_in=101 on the same edge an INC completes -> flags=101, result=in2+1.
